// File: rtl/sine_stream_pkg.sv
// Shared definitions for the sine sample streamer: default geometry of the
// stimulus table and the streamer FSM state encoding.
package sine_stream_pkg;

  localparam int DEF_ADDR_WIDTH   = 9;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_SAMPLE_COUNT = 470;
  localparam int DEF_DIV_WIDTH    = 8;
  localparam int LAST_ADDR        = DEF_SAMPLE_COUNT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sine_sample_streamer_rate_divider.sv
// Programmable sample-rate divider. The period setting is captured on load;
// while enabled the counter runs down and emits a one-cycle tick at zero,
// reloading the captured setting so ticks repeat every (div+1) cycles.
module rate_divider
  import sine_stream_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_reg_r;
  logic [DIV_WIDTH-1:0] div_cnt_r;

  assign tick = enable && (div_cnt_r == {DIV_WIDTH{1'b0}});

  // Capture the period on load, otherwise count down and reload on each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg_r <= {DIV_WIDTH{1'b0}};
      div_cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (load) begin
      div_reg_r <= div;
      div_cnt_r <= div;
    end else if (enable) begin
      if (div_cnt_r == {DIV_WIDTH{1'b0}}) begin
        div_cnt_r <= div_reg_r;
      end else begin
        div_cnt_r <= div_cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/sine_sample_streamer.sv
// Paced sample source: walks the sine table address, captures one table
// sample per divider tick into a valid/ready output register, marks the
// end of each table pass and flags lost ticks as a sticky overrun.
// Build option SINE_STREAM_ONESHOT_EN: when defined, a single table pass is
// made per start and the FSM drains automatically after the last entry.
module sine_sample_streamer
  import sine_stream_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SAMPLE_COUNT = DEF_SAMPLE_COUNT,
  parameter int DIV_WIDTH    = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(SAMPLE_COUNT - 1);

  state_t                 state_r,   state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_r,    addr_nxt;
  logic                   pend_r,    pend_nxt;
  logic                   valid_r,   valid_nxt;
  logic [DATA_WIDTH-1:0]  data_r,    data_nxt;
  logic                   last_r,    last_nxt;
  logic                   overrun_r, overrun_nxt;

  logic start_acc_s;
  logic run_en_s;
  logic tick_s;
  logic capture_s;

  // stop takes priority over start in IDLE and over any capture in RUN
  assign start_acc_s = (state_r == IDLE) && start && !stop;
  assign run_en_s    = (state_r == RUN) && !stop;
  assign capture_s   = run_en_s && (tick_s || pend_r) && (!valid_r || m_ready);

  rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_acc_s),
    .enable  (run_en_s),
    .div     (div),
    .tick    (tick_s)
  );

  // Next-state and datapath decisions for FSM, address, pending tick and output register.
  always_comb begin
    state_nxt   = state_r;
    addr_nxt    = addr_r;
    pend_nxt    = pend_r;
    valid_nxt   = valid_r;
    data_nxt    = data_r;
    last_nxt    = last_r;
    overrun_nxt = overrun_r;

    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
`ifdef SINE_STREAM_ONESHOT_EN
        end else if (capture_s && (addr_r == END_ADDR)) begin
          state_nxt = DRAIN;
`endif
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (!valid_r || m_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // output register: a capture refills it, a bare transfer empties it
    if (capture_s) begin
      data_nxt  = rom_data;
      last_nxt  = (addr_r == END_ADDR);
      valid_nxt = 1'b1;
    end else if (valid_r && m_ready) begin
      valid_nxt = 1'b0;
    end else begin
      valid_nxt = valid_r;
    end

    // address: restart at zero on start, advance with wrap on each capture
    if (start_acc_s) begin
      addr_nxt = {ADDR_WIDTH{1'b0}};
    end else if (capture_s) begin
      addr_nxt = (addr_r == END_ADDR) ? {ADDR_WIDTH{1'b0}} : addr_r + ADDR_WIDTH'(1);
    end else begin
      addr_nxt = addr_r;
    end

    // pending tick: remembers a tick that could not be captured yet
    if (start_acc_s || capture_s || ((state_r == RUN) && stop)) begin
      pend_nxt = 1'b0;
    end else if (run_en_s && tick_s) begin
      pend_nxt = 1'b1;
    end else begin
      pend_nxt = pend_r;
    end

    // overrun: a second tick arriving while one is still waiting is lost
    if (start_acc_s) begin
      overrun_nxt = 1'b0;
    end else if (run_en_s && tick_s && pend_r && !capture_s) begin
      overrun_nxt = 1'b1;
    end else begin
      overrun_nxt = overrun_r;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      pend_r    <= 1'b0;
      valid_r   <= 1'b0;
      data_r    <= {DATA_WIDTH{1'b0}};
      last_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      addr_r    <= addr_nxt;
      pend_r    <= pend_nxt;
      valid_r   <= valid_nxt;
      data_r    <= data_nxt;
      last_r    <= last_nxt;
      overrun_r <= overrun_nxt;
    end
  end

  assign rom_addr = addr_r;
  assign m_valid  = valid_r;
  assign m_data   = data_r;
  assign m_last   = last_r;
  assign busy     = (state_r != IDLE);
  assign overrun  = overrun_r;

endmodule
